// File: rtl/index_seq_pkg.sv
// Shared constants for the index sequencer: state encoding and default order width.
package index_seq_pkg;
  localparam int MW_DEFAULT = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/index_seq_ctr.sv
// Loadable MW-bit up-counter for index j, with terminal compare against the latched order.
module index_seq_ctr
  import index_seq_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic          clr,
  input  logic [MW-1:0] m_lat,
  output logic [MW-1:0] j,
  output logic          term
);

  // Clear wins over load/inc so j returns to 0 as soon as a sequence ends.
  always_ff @(posedge clk) begin
    if (rst || clr)  j <= '0;
    else if (load)   j <= MW'(1);
    else if (inc)    j <= j + MW'(1);
  end

  assign term = (j == m_lat);

endmodule

// File: rtl/index_sequencer.sv
// Emits index beats j=1..M to a downstream index calculator with valid/ready handshake.
// Optional abort input enabled by defining INDEX_SEQ_ABORT_EN.
module index_sequencer
  import index_seq_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] M,
  input  logic          j_ready,
`ifdef INDEX_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic [MW-1:0] j_out,
  output logic          j_valid,
  output logic          en_out,
  output logic [MW-1:0] M_out,
  output logic          last,
  output logic          busy,
  output logic          done
);

  logic [1:0]    state;
  logic [MW-1:0] m_lat;
  logic          term, hs, run, abort_run;
  logic          ctr_load, ctr_inc, ctr_clr;

  assign run = (state == ST_RUN);
  assign hs  = run && j_ready;

`ifdef INDEX_SEQ_ABORT_EN
  assign abort_run = run && abort;
`else
  assign abort_run = 1'b0;
`endif

  assign ctr_load = (state == ST_IDLE) && start && (M != '0);
  assign ctr_inc  = hs && !term && !abort_run;
  assign ctr_clr  = (hs && term) || abort_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      m_lat <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          m_lat <= M;
          state <= (M == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          // Abort beats a same-cycle final handshake; no done pulse is produced.
          if (abort_run) begin
            state <= ST_IDLE;
            m_lat <= '0;
          end else if (hs && term) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  index_seq_ctr #(.MW(MW)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .clr   (ctr_clr),
    .m_lat (m_lat),
    .j     (j_out),
    .term  (term)
  );

  assign j_valid = run;
  assign en_out  = run;
  assign last    = run && term;
  assign busy    = run || (state == ST_DONE);
  assign done    = (state == ST_DONE);
  assign M_out   = m_lat;

endmodule

// File: tb/tb_index_sequencer.sv
// Directed table-driven bench for index_sequencer plus hand-written long-run and abort sequences.
module tb_index_sequencer;
  localparam int MW = 5;

  logic          clk = 1'b0;
  logic          rst, start, j_ready;
  logic [MW-1:0] M;
  logic [MW-1:0] j_out, M_out;
  logic          j_valid, en_out, last, busy, done;
`ifdef INDEX_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  index_sequencer #(.MW(MW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .M       (M),
    .j_ready (j_ready),
`ifdef INDEX_SEQ_ABORT_EN
    .abort   (abort),
`endif
    .j_out   (j_out),
    .j_valid (j_valid),
    .en_out  (en_out),
    .M_out   (M_out),
    .last    (last),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic          rst, start, rdy;
    logic [MW-1:0] m;
    logic          ev;
    logic [MW-1:0] ej;
    logic          el, eb, ed;
    logic [MW-1:0] em;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on falling edge, clock, then check the post-edge outputs.
  task automatic step(input logic r, input logic s, input logic [MW-1:0] m, input logic rdy);
    @(negedge clk);
    rst = r; start = s; M = m; j_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [MW-1:0] j,
                         input logic l, input logic b, input logic d, input logic [MW-1:0] mo);
    chk({tag, " j_valid"}, int'(j_valid), int'(v));
    chk({tag, " en_out"},  int'(en_out),  int'(v));
    chk({tag, " j_out"},   int'(j_out),   int'(j));
    chk({tag, " last"},    int'(last),    int'(l));
    chk({tag, " busy"},    int'(busy),    int'(b));
    chk({tag, " done"},    int'(done),    int'(d));
    chk({tag, " M_out"},   int'(M_out),   int'(mo));
  endtask

  task automatic add(input logic r, input logic s, input logic [MW-1:0] m, input logic rdy,
                     input logic v, input logic [MW-1:0] j, input logic l,
                     input logic b, input logic d, input logic [MW-1:0] mo);
    vec_t x;
    x.rst = r; x.start = s; x.m = m; x.rdy = rdy;
    x.ev = v; x.ej = j; x.el = l; x.eb = b; x.ed = d; x.em = mo;
    vq.push_back(x);
  endtask

  initial begin
    int beats, expj;
    bit fin;
    rst = 1'b1; start = 1'b0; M = '0; j_ready = 1'b0;

    //   rst st  M  rdy   v  j  l  b  d  Mo
    add(1, 0, 0, 0,    0, 0, 0, 0, 0, 0);   // reset state
    add(1, 1, 4, 1,    0, 0, 0, 0, 0, 0);   // reset beats start
    // M=4, ready high: 1,2,3,4, done, idle
    add(0, 1, 4, 1,    1, 1, 0, 1, 0, 4);
    add(0, 0, 0, 1,    1, 2, 0, 1, 0, 4);
    add(0, 0, 0, 1,    1, 3, 0, 1, 0, 4);
    add(0, 0, 0, 1,    1, 4, 1, 1, 0, 4);
    add(0, 0, 0, 1,    0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 1,    0, 0, 0, 0, 0, 4);
    // M=3, ready toggling
    add(0, 1, 3, 0,    1, 1, 0, 1, 0, 3);
    add(0, 0, 0, 1,    1, 2, 0, 1, 0, 3);
    add(0, 0, 0, 0,    1, 2, 0, 1, 0, 3);
    add(0, 0, 0, 1,    1, 3, 1, 1, 0, 3);
    add(0, 0, 0, 0,    1, 3, 1, 1, 0, 3);
    add(0, 0, 0, 1,    0, 0, 0, 1, 1, 3);
    add(0, 1, 2, 1,    0, 0, 0, 0, 0, 3);   // start during DONE ignored
    add(0, 1, 2, 1,    1, 1, 0, 1, 0, 2);
    add(0, 1, 7, 1,    1, 2, 1, 1, 0, 2);   // start while busy ignored
    add(0, 0, 0, 1,    0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 1,    0, 0, 0, 0, 0, 2);
    // M=0: straight to DONE
    add(0, 1, 0, 1,    0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    // M=5: start at j=2 ignored, then rst at j=2
    add(0, 1, 5, 1,    1, 1, 0, 1, 0, 5);
    add(0, 0, 0, 1,    1, 2, 0, 1, 0, 5);
    add(0, 1, 9, 0,    1, 2, 0, 1, 0, 5);
    add(1, 0, 0, 1,    0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,    0, 0, 0, 0, 0, 0);   // no done after reset

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].start, vq[i].m, vq[i].rdy);
      chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].ej, vq[i].el, vq[i].eb, vq[i].ed, vq[i].em);
    end

    // M=31: 31 beats, last only at j=31, no wrap
    step(0, 1, 5'd31, 1);
    beats = 0; expj = 1; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (j_valid) begin
        beats++;
        chk("m31 j_out", int'(j_out), expj);
        chk("m31 last", int'(last), int'(expj == 31));
        expj++;
        step(0, 0, 0, 1);
      end else begin
        fin = 1;
      end
    end
    chk("m31 beats", beats, 31);
    chk("m31 done", int'(done), 1);
    chk("m31 j_out after", int'(j_out), 0);
    step(0, 0, 0, 1);
    chk("m31 idle busy", int'(busy), 0);

`ifdef INDEX_SEQ_ABORT_EN
    // abort at j=2 with same-cycle handshake: IDLE next, no done
    step(0, 1, 5, 1);
    step(0, 0, 0, 1);
    chk("ab pre j", int'(j_out), 2);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    chk_all("abort", 0, 0, 0, 0, 0, 0);
    @(negedge clk); abort = 1'b0;
    @(posedge clk); #1;
    chk("abort no done", int'(done), 0);
    // abort during DONE ignored
    step(0, 1, 0, 1);
    chk("ab done pulse", int'(done), 1);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    chk("ab in done idle", int'(busy), 0);
    @(negedge clk); abort = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
